multiband_energy_meter: RTL and testbench
=========================================

# multiband_energy_meter

Parametrised, time-multiplexed multi-band energy meter for the tiny spectrum analyzer. It accepts signed PCM samples over a valid/ready handshake and splits them into NUM_BANDS bands with a cascade of one-pole shift-only low-pass filters. Per-band absolute energy is averaged over a 2^WINDOW_LOG2-sample window into peak-hold levels with programmable decay. The block drives per-band PWM outputs and reports the loudest band. It sits between the PDM-to-PCM sampler and the LED/PWM pins.

## Interface
- NUM_BANDS, 8: number of bands (2..16); band 0 is the highest frequency.
- SAMPLE_W, 8: signed input sample width.
- LEVEL_W, 8: level and PWM resolution.
- WINDOW_LOG2, 4: log2 of the number of samples per averaging window.
- DECAY_SHIFT, 3: peak-hold decay shift.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  sample_data valid.
- sample_ready  out  1  block can accept a sample.
- sample_data  in  SAMPLE_W  signed PCM sample.
- levels  out  NUM_BANDS*LEVEL_W  band b level at [b*LEVEL_W +: LEVEL_W].
- levels_valid  out  1  one-cycle pulse when levels update.
- peak_band  out  clog2(NUM_BANDS)  index of the largest level.
- pwm_out  out  NUM_BANDS  per-band PWM.

## Operation
- Filter state y[b]: signed SAMPLE_W+8 bits (8 fraction bits). x = sample_data<<8.
- Input to stage b: in[0] = x; in[b] = y[b-1] for b > 0.
- Update rule: y[b] += (in[b] - y[b]) >>> (b+1).
- Band signal: d[b] = (in[b] - y[b]) >>> 8, width SAMPLE_W+1.
- All d[b] and y[b] updates for one sample use the pre-sample states. Implementation buffers the old y[b-1] before overwriting it.
- Energy: acc[b] += |d[b]|. acc width is SAMPLE_W+1+WINDOW_LOG2, so it cannot overflow.
- avg[b] = acc[b] >> WINDOW_LOG2, saturated to 2^LEVEL_W-1.
- Window end: level[b] = max(avg[b], level[b] - dec[b]), where dec[b] = max(1, level[b]>>DECAY_SHIFT). A level of 0 stays 0.
- At window end, acc[] and the sample counter clear.
- peak_band: index of the largest new level; the lowest index wins ties; 0 when all levels are 0.
- PWM: one free-running LEVEL_W counter cnt, shared by all bands. pwm_out[b] is registered as (cnt < level[b]).
- FSM states: IDLE, PROC, UPDATE.
  - IDLE: sample_ready=1. A handshake latches the sample and enters PROC with band index 0.
  - PROC: processes one band per cycle. After band NUM_BANDS-1 it goes to UPDATE if this was sample 2^WINDOW_LOG2 of the window, otherwise to IDLE.
  - UPDATE: one cycle; registers levels and peak_band, then returns to IDLE.
- sample_valid while not ready is ignored. There is no input buffering; the upstream source holds its data.

## Timing
- Reset values: sample_ready=0 during rst and 1 in the first cycle after release. levels=0, levels_valid=0, peak_band=0, pwm_out=0. All y, acc, cnt, sample counter and FSM state = 0/IDLE.
- Sample accepted at edge T: bands update at edges T+1..T+NUM_BANDS. sample_ready is 0 during that interval.
- Without a window end, sample_ready returns to 1 after edge T+NUM_BANDS, giving one sample per NUM_BANDS+1 cycles.
- With a window end:
  - levels, peak_band and levels_valid=1 register at edge T+NUM_BANDS+1.
  - levels_valid clears on the next edge.
  - sample_ready returns to 1 after edge T+NUM_BANDS+1.
- pwm_out reflects a new level from the cnt value after the update edge. There is no PWM period restart.
- rst asserted mid-PROC or mid-UPDATE clears everything immediately; a partial window is discarded.

## Test plan
- Reset: assert rst during PROC → all outputs 0 immediately. sample_ready=1 one cycle after release.
- All-zero input, 48 samples → levels stay 0, peak_band=0. Exactly 3 levels_valid pulses, each NUM_BANDS+1 cycles after the 16th, 32nd and 48th handshakes.
- Alternating +127/-128 with defaults → after the first window, band 0 level is the largest and peak_band=0. Band NUM_BANDS-1 level stays below band 0.
- Handshake: hold sample_valid=1 continuously → one accept per 9 cycles (10 at window ends). No sample lost or double-counted; check with a bench count of 64.
- Decay: drive level[0] to L, then feed zeros → L decreases per window by max(1, L>>3), e.g. 200→175→154→135. A level of 1 reaches 0.
- PWM: with level[b]=64, LEVEL_W=8 → pwm_out[b] high for exactly 64 of every 256 cycles. level=0 → constantly low.

Source files
------------

// File: rtl/multiband_energy_meter.sv
// Time-multiplexed multi-band energy meter.
// A cascade of shift-only one-pole low-pass stages splits each sample into
// NUM_BANDS bands, one band per cycle. Each band's absolute energy is averaged
// over a window into peak-hold levels with decay. The levels drive per-band
// PWM outputs, and the loudest band is reported.
module multiband_energy_meter #(
  parameter int NUM_BANDS   = 8,
  parameter int SAMPLE_W    = 8,
  parameter int LEVEL_W     = 8,
  parameter int WINDOW_LOG2 = 4,
  parameter int DECAY_SHIFT = 3,
  localparam int BAND_W     = $clog2(NUM_BANDS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic signed [SAMPLE_W-1:0]    sample_data,
  output logic [NUM_BANDS*LEVEL_W-1:0]  levels,
  output logic                          levels_valid,
  output logic [BAND_W-1:0]             peak_band,
  output logic [NUM_BANDS-1:0]          pwm_out
);

  localparam int Y_W    = SAMPLE_W + 8;               // filter state, 8 fraction bits
  localparam int DIFF_W = Y_W + 1;                    // in - y never overflows
  localparam int D_W    = SAMPLE_W + 1;               // band signal width
  localparam int ACC_W  = SAMPLE_W + 1 + WINDOW_LOG2; // window sum cannot overflow
  localparam int CMP_W  = ((ACC_W > LEVEL_W) ? ACC_W : LEVEL_W) + 1;

  localparam logic [BAND_W-1:0]      LAST_BAND = BAND_W'(NUM_BANDS - 1);
  localparam logic [WINDOW_LOG2-1:0] CNT_LAST  = '1;
  localparam logic [LEVEL_W-1:0]     LEVEL_MAX = '1;

  typedef enum logic [1:0] {IDLE, PROC, UPDATE} state_t;

  state_t state, next_state;

  logic [BAND_W-1:0]          band;
  logic [WINDOW_LOG2-1:0]     sample_cnt;
  logic signed [SAMPLE_W-1:0] sample_reg;
  logic signed [Y_W-1:0]      y     [NUM_BANDS];
  logic signed [Y_W-1:0]      prev_y;
  logic [ACC_W-1:0]           acc   [NUM_BANDS];
  logic [LEVEL_W-1:0]         level [NUM_BANDS];
  logic [LEVEL_W-1:0]         cnt;

  // Per-band datapath signals
  logic signed [Y_W-1:0]    stage_in, y_cur, step, y_new;
  logic signed [DIFF_W-1:0] diff;
  logic signed [D_W-1:0]    d;
  logic [D_W-1:0]           d_abs;
  logic [ACC_W-1:0]         acc_next;

  // Window-end signals
  logic [LEVEL_W-1:0] new_level [NUM_BANDS];
  logic [LEVEL_W-1:0] best, avg_sat, dec, decayed;
  logic [CMP_W-1:0]   avg_w;
  logic [BAND_W-1:0]  peak_idx;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    else     state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sample_valid) next_state = PROC;
      PROC:    if (band == LAST_BAND)
                 next_state = (sample_cnt == CNT_LAST) ? UPDATE : IDLE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs; ready is masked while reset is held
  always_comb begin
    sample_ready = (state == IDLE) && !rst;
  end

  // One filter stage: the stage input for band b>0 is the pre-sample y[b-1], buffered in prev_y
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    y_cur    = y[band];
    stage_in = (band == '0) ? {sample_reg, 8'b0} : prev_y;
    diff     = {stage_in[Y_W-1], stage_in} - {y_cur[Y_W-1], y_cur};
    step     = Y_W'(diff >>> (int'(band) + 1));
    y_new    = y_cur + step;
    d        = diff[DIFF_W-1:8];
    d_abs    = d[D_W-1] ? D_W'(-d) : D_W'(d);
    acc_next = acc[band] + ACC_W'(d_abs);
  end

  // Window end: saturated average vs decayed peak-hold, plus loudest band (lowest index on ties)
  always_comb begin
    new_level = level;
    peak_idx  = '0;
    best      = '0;
    avg_w     = '0;
    avg_sat   = '0;
    dec       = '0;
    decayed   = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      avg_w   = CMP_W'(acc[b]) >> WINDOW_LOG2;
      avg_sat = (avg_w > CMP_W'(LEVEL_MAX)) ? LEVEL_MAX : avg_w[LEVEL_W-1:0];
      dec     = level[b] >> DECAY_SHIFT;
      if (dec == '0) dec = LEVEL_W'(1);
      decayed = (level[b] == '0) ? '0 : level[b] - dec;
      new_level[b] = (avg_sat > decayed) ? avg_sat : decayed;
      if (new_level[b] > best) begin
        best     = new_level[b];
        peak_idx = BAND_W'(b);
      end
    end
  end

  // Datapath: sample latch, per-band filter/energy update, window-end level update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      band         <= '0;
      sample_cnt   <= '0;
      sample_reg   <= '0;
      prev_y       <= '0;
      levels_valid <= 1'b0;
      peak_band    <= '0;
      // NOTE: these arrays are register files, not RAM, so they are cleared on reset like any flop.
      for (int b = 0; b < NUM_BANDS; b++) begin
        y[b]     <= '0;
        acc[b]   <= '0;
        level[b] <= '0;
      end
    end else begin
      levels_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            sample_reg <= sample_data;
            band       <= '0;
          end
        end
        PROC: begin
          y[band]   <= y_new;
          acc[band] <= acc_next;
          prev_y    <= y_cur;
          if (band == LAST_BAND) begin
            band       <= '0;
            sample_cnt <= sample_cnt + 1'b1;
          end else begin
            band <= band + 1'b1;
          end
        end
        UPDATE: begin
          level        <= new_level;
          peak_band    <= peak_idx;
          levels_valid <= 1'b1;
          sample_cnt   <= '0;
          for (int b = 0; b < NUM_BANDS; b++) acc[b] <= '0;
        end
        default: ;
      endcase
    end
  end

  // Shared free-running PWM counter and registered per-band compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pwm_out <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      for (int b = 0; b < NUM_BANDS; b++) pwm_out[b] <= (cnt < level[b]);
    end
  end

  // Pack level registers onto the flat output bus
  always_comb begin
    levels = '0;
    for (int b = 0; b < NUM_BANDS; b++) levels[b*LEVEL_W +: LEVEL_W] = level[b];
  end

endmodule

// File: tb/tb_multiband_energy_meter.sv
// Directed testbench for multiband_energy_meter (default parameters).
`timescale 1ns/1ps
module tb_multiband_energy_meter;

  localparam int NB = 8;
  localparam int SW = 8;
  localparam int LW = 8;
  localparam int BW = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sample_valid = 1'b0;
  logic                 sample_ready;
  logic signed [SW-1:0] sample_data = '0;
  logic [NB*LW-1:0]     levels;
  logic                 levels_valid;
  logic [BW-1:0]        peak_band;
  logic [NB-1:0]        pwm_out;

  int checks = 0;
  int errors = 0;
  int stray_lv = 0;

  multiband_energy_meter #(
    .NUM_BANDS(NB), .SAMPLE_W(SW), .LEVEL_W(LW), .WINDOW_LOG2(4), .DECAY_SHIFT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .levels(levels), .levels_valid(levels_valid), .peak_band(peak_band), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] lvl(input int b);
    return levels[b*LW +: LW];
  endfunction

  // Present one sample at a negedge, wait (bounded) for ready, return at the negedge after the accept edge
  task automatic send_sample(input logic signed [SW-1:0] d);
    int n;
    sample_data  = d;
    sample_valid = 1'b1;
    n = 0;
    while (sample_ready !== 1'b1 && n < 50) begin
      if (levels_valid === 1'b1) stray_lv++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      $display("FAIL handshake_timeout: waited %0d cycles, required < 50", n);
      errors++;
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // 16 samples alternating a/b, then observe the window-end pulse position
  task automatic send_window(input logic signed [SW-1:0] a, input logic signed [SW-1:0] b,
                             output int pulses, output int pos);
    for (int i = 0; i < 16; i++) send_sample((i % 2 == 0) ? a : b);
    pulses = 0;
    pos    = 0;
    for (int j = 1; j <= NB + 2; j++) begin
      @(negedge clk);
      if (levels_valid === 1'b1) begin
        pulses++;
        pos = j;
      end
    end
  endtask

  task automatic count_pwm0(output int highs);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out[0] === 1'b1) highs++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sample_ready !== 1'b0) begin $display("FAIL reset_ready: got %0b want 0", sample_ready); errors++; end
    checks++; if (levels !== '0) begin $display("FAIL reset_levels: got %h want 0", levels); errors++; end
    checks++; if (levels_valid !== 1'b0) begin $display("FAIL reset_levels_valid: got %0b want 0", levels_valid); errors++; end
    checks++; if (peak_band !== '0) begin $display("FAIL reset_peak: got %0d want 0", peak_band); errors++; end
    checks++; if (pwm_out !== '0) begin $display("FAIL reset_pwm: got %h want 0", pwm_out); errors++; end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sample_ready !== 1'b1) begin $display("FAIL ready_after_release: got %0b want 1", sample_ready); errors++; end
  endtask

  task automatic test_zero_windows();
    int p, pos, total, badpos;
    stray_lv = 0;
    total    = 0;
    badpos   = 0;
    for (int w = 0; w < 3; w++) begin
      send_window(0, 0, p, pos);
      total += p;
      if (p != 1 || pos != NB + 1) badpos++;
    end
    checks++; if (total !== 3) begin $display("FAIL zero_pulse_count: got %0d want 3", total); errors++; end
    checks++; if (badpos !== 0) begin $display("FAIL zero_pulse_timing: %0d windows off, want 0", badpos); errors++; end
    checks++; if (stray_lv !== 0) begin $display("FAIL zero_stray_pulses: got %0d want 0", stray_lv); errors++; end
    checks++; if (levels !== '0) begin $display("FAIL zero_levels: got %h want 0", levels); errors++; end
    checks++; if (peak_band !== '0) begin $display("FAIL zero_peak: got %0d want 0", peak_band); errors++; end
  endtask

  task automatic test_alternating();
    int p, pos;
    send_window(127, -128, p, pos);
    checks++; if (p !== 1 || pos !== NB + 1) begin $display("FAIL alt_pulse: got %0d pulses at %0d, want 1 at %0d", p, pos, NB + 1); errors++; end
    checks++; if (lvl(0) !== 8'd168) begin $display("FAIL alt_level0: got %0d want 168", lvl(0)); errors++; end
    checks++; if (peak_band !== 3'd0) begin $display("FAIL alt_peak: got %0d want 0", peak_band); errors++; end
    checks++; if (!(lvl(NB-1) < lvl(0))) begin $display("FAIL alt_top_band: got level%0d=%0d, want below %0d", NB-1, lvl(NB-1), lvl(0)); errors++; end
  endtask

  task automatic test_pwm(input int want);
    int highs;
    count_pwm0(highs);
    checks++; if (highs !== want) begin $display("FAIL pwm0_duty: got %0d/256 want %0d/256", highs, want); errors++; end
  endtask

  task automatic test_decay();
    int p, pos, expv, dec;
    send_window(0, 0, p, pos);
    expv = 147;
    checks++; if (lvl(0) !== 8'(expv)) begin $display("FAIL decay_first: got %0d want %0d", lvl(0), expv); errors++; end
    for (int w = 0; w < 80 && expv != 0; w++) begin
      dec = expv >> 3;
      if (dec == 0) dec = 1;
      expv -= dec;
      send_window(0, 0, p, pos);
      checks++; if (lvl(0) !== 8'(expv)) begin $display("FAIL decay_step%0d: got %0d want %0d", w, lvl(0), expv); errors++; end
    end
    checks++; if (lvl(0) !== 8'd0) begin $display("FAIL decay_final: got %0d want 0", lvl(0)); errors++; end
  endtask

  task automatic test_back_to_back();
    int accepts, pulses, bad, last, n, gap;
    accepts = 0; pulses = 0; bad = 0; last = -1; n = 0;
    sample_data  = 0;
    sample_valid = 1'b1;
    while (accepts < 64 && n < 1000) begin
      if (levels_valid === 1'b1) pulses++;
      if (sample_ready === 1'b1) begin
        if (last >= 0) begin
          gap = (accepts % 16 == 0) ? 10 : 9;
          if (n - last != gap) bad++;
        end
        last = n;
        accepts++;
      end
      @(negedge clk);
      n++;
    end
    sample_valid = 1'b0;
    repeat (NB + 3) begin
      if (levels_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++; if (accepts !== 64) begin $display("FAIL b2b_accepts: got %0d want 64", accepts); errors++; end
    checks++; if (bad !== 0) begin $display("FAIL b2b_spacing: %0d bad gaps, want 0", bad); errors++; end
    checks++; if (pulses !== 4) begin $display("FAIL b2b_windows: got %0d pulses want 4", pulses); errors++; end
  endtask

  task automatic test_reset_mid();
    int p, pos;
    send_window(127, -128, p, pos);
    checks++; if (levels === '0) begin $display("FAIL premid_levels: got %h want nonzero", levels); errors++; end
    send_sample(100);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (levels !== '0) begin $display("FAIL mid_levels: got %h want 0", levels); errors++; end
    checks++; if (levels_valid !== 1'b0) begin $display("FAIL mid_levels_valid: got %0b want 0", levels_valid); errors++; end
    checks++; if (peak_band !== '0) begin $display("FAIL mid_peak: got %0d want 0", peak_band); errors++; end
    checks++; if (pwm_out !== '0) begin $display("FAIL mid_pwm: got %h want 0", pwm_out); errors++; end
    checks++; if (sample_ready !== 1'b0) begin $display("FAIL mid_ready: got %0b want 0", sample_ready); errors++; end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sample_ready !== 1'b1) begin $display("FAIL mid_ready_release: got %0b want 1", sample_ready); errors++; end
    send_window(127, -128, p, pos);
    checks++; if (p !== 1 || pos !== NB + 1) begin $display("FAIL mid_window_pulse: got %0d at %0d, want 1 at %0d", p, pos, NB + 1); errors++; end
    checks++; if (lvl(0) !== 8'd168) begin $display("FAIL mid_fresh_level0: got %0d want 168", lvl(0)); errors++; end
    checks++; if (peak_band !== 3'd0) begin $display("FAIL mid_fresh_peak: got %0d want 0", peak_band); errors++; end
  endtask

  initial begin
    test_reset();
    test_zero_windows();
    test_alternating();
    test_pwm(168);
    test_decay();
    test_pwm(0);
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
